reg_file_wr_ctrl: RTL and testbench
===================================

// Module: reg_file_wr_ctrl
// PURPOSE
//  Write-port controller for the 32x32 register file. Shares its single write port between two
//  writeback requesters (req0: ALU, req1: load unit) using round-robin arbitration.
//  Also runs a clear sequence that zeroes every register, one per cycle, on a single start pulse.
//  Sits between the writeback stage and the register-file write_en/write_addr/data inputs.
// PARAMETERS
//  DATA_W    32  width of write data
//  ADDR_W    5   width of register address
//  NUM_REGS  32  registers swept by the clear sequence (<= 2**ADDR_W)
//  ZERO_LOCK 1   1: accepted writes to address 0 are consumed but never issued to the register file
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  reset         in   1       synchronous, active-low reset
//  req0_valid    in   1       requester 0 has a write pending
//  req0_addr     in   ADDR_W  requester 0 destination register
//  req0_data     in   DATA_W  requester 0 write data
//  req0_ready    out  1       requester 0 write accepted this cycle (valid&&ready)
//  req1_valid    in   1       requester 1 has a write pending
//  req1_addr     in   ADDR_W  requester 1 destination register
//  req1_data     in   DATA_W  requester 1 write data
//  req1_ready    out  1       requester 1 write accepted this cycle
//  clr_start     in   1       pulse: begin clearing all registers
//  clr_busy      out  1       clear sequence in progress
//  clr_done      out  1       one-cycle pulse, clear sequence finished
//  rf_write_en   out  1       register file write enable (registered)
//  rf_write_addr out  ADDR_W  register file write address (registered)
//  rf_data       out  DATA_W  register file write data (registered)
// BEHAVIOUR
//  - reset==0 at posedge: FSM->IDLE, rf_write_en/addr/data=0, clr_busy=0, clr_done=0, clear
//    counter=0, RR pointer set so req0 wins the first contention. Applies mid-clear: sequence
//    aborts, no clr_done pulse.
//  - FSM states: IDLE, CLEAR.
//    IDLE -> CLEAR when clr_start==1; CLEAR -> IDLE after the write to NUM_REGS-1 is issued.
//  - req0_ready/req1_ready are combinational; both 0 when state!=IDLE or clr_start==1
//    (clear takes priority over requests in the same cycle).
//  - IDLE arbitration: only one valid -> that one ready; both valid -> grant the requester not
//    granted most recently; RR pointer updates only on an accepted transfer; at most one
//    ready high per cycle.
//  - Latency: transfer accepted at edge t -> rf_write_en=1 with that addr/data in the cycle after
//    t (one register stage). No accepted transfer -> rf_write_en=0 next cycle; addr/data hold
//    their last value.
//  - ZERO_LOCK=1 and accepted addr==0: ready still asserted, but rf_write_en stays 0 next cycle.
//  - CLEAR: counter runs 0..NUM_REGS-1; each cycle rf_write_en=1, rf_write_addr=counter,
//    rf_data=0, including address 0 regardless of ZERO_LOCK. First clear write appears the
//    cycle after clr_start is sampled. clr_busy=1 exactly during the NUM_REGS write cycles.
//    clr_done=1 for one cycle after the last clear write; clr_busy=0 that cycle, and request
//    ready may be asserted that same cycle.
//  - clr_start while CLEAR: ignored (no restart). Requests held valid during CLEAR wait; none
//    are dropped.
//  - Counter width ADDR_W+1 internally; no wrap into a second sweep.
// TESTING
//  1 reset=0 mid-stream, then release -> all outputs 0; req0&req1 valid -> req0 ready first
//    cycle, req1 next.
//  2 req0 {addr=5,data=32'hDEADBEEF} alone -> req0_ready=1, next cycle rf_write_en=1,
//    addr=5, data=DEADBEEF.
//  3 both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; no cycle has both
//    ready high.
//  4 ZERO_LOCK=1, req1 addr=0 data=32'h1 -> req1_ready=1, rf_write_en stays 0; then addr=1
//    -> written.
//  5 clr_start with req0 valid same cycle -> req0_ready=0; 32 writes addr 0..31 data 0;
//    clr_done pulses once; req0 accepted the cycle clr_done is high.
//  6 reset=0 at clear write addr 10 -> FSM IDLE, no clr_done, clr_busy=0; second clr_start
//    mid-clear ignored (exactly 32 writes).

Source files
------------

// File: rtl/reg_file_wr_ctrl.sv
// ============================================================================
// Module  : reg_file_wr_ctrl
// Brief   : Round-robin write-port arbiter for the register file, plus a
//           one-register-per-cycle clear sweep started by a single pulse.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_wr_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int ZERO_LOCK = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              rf_write_en_o,
  output logic [ADDR_W-1:0] rf_write_addr_o,
  output logic [DATA_W-1:0] rf_data_o
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_CNT_END = CNT_W'(NUM_REGS);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last1_q, last1_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                w_gnt0, w_gnt1;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last1_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last1_q <= last1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last1_d    = last1_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_sel_addr = req0_addr_i;
    w_sel_data = req0_data_i;

    case (state_q)
      IDLE: begin
        if (clr_start_i) begin
          // The first clear write (address 0) is registered on the start edge itself.
          state_d = CLEAR;
          cnt_d   = C_CNT_ONE;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = '0;
        end else begin
          // last1_q set means requester 1 won most recently, so requester 0 has priority.
          w_gnt0 = req0_valid_i && (!req1_valid_i || last1_q);
          w_gnt1 = req1_valid_i && (!req0_valid_i || !last1_q);
          if (w_gnt1) begin
            w_sel_addr = req1_addr_i;
            w_sel_data = req1_data_i;
          end
          if (w_gnt0 || w_gnt1) begin
            last1_d = w_gnt1;
            if (!((ZERO_LOCK != 0) && (w_sel_addr == '0))) begin
              we_d   = 1'b1;
              addr_d = w_sel_addr;
              data_d = w_sel_data;
            end
          end
        end
      end
      CLEAR: begin
        if (cnt_q == C_CNT_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = '0;
          cnt_d  = cnt_q + C_CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready_o    = w_gnt0;
  assign req1_ready_o    = w_gnt1;
  assign clr_busy_o      = (state_q == CLEAR);
  assign clr_done_o      = done_q;
  assign rf_write_en_o   = we_q;
  assign rf_write_addr_o = addr_q;
  assign rf_data_o       = data_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_wr_ctrl.sv
// ============================================================================
// Module  : tb_reg_file_wr_ctrl
// Brief   : Self-checking bench: directed scenarios plus random traffic against
//           a cycle-level reference model of the write-port controller.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_wr_ctrl;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_REGS  = 32;
  localparam int ZERO_LOCK = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              v0, v1, clr;
  logic [ADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] d0, d1;
  logic              r0, r1, busy, done, rf_en;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the register-file port shows this cycle.
  logic              m_busy, m_en, m_done, m_last1;
  int                m_caddr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              e_r0, e_r1, a_r0, a_r1;

  always #5 clk = ~clk;

  reg_file_wr_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_LOCK(ZERO_LOCK)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req0_valid_i(v0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(r1),
    .clr_start_i(clr), .clr_busy_o(busy), .clr_done_o(done),
    .rf_write_en_o(rf_en), .rf_write_addr_o(rf_addr), .rf_data_o(rf_data)
  );

  // One clock: sample readies mid-cycle, apply the model's rules at the edge.
  task automatic advance();
    logic ok;
    @(negedge clk);
    ok   = !m_busy && !clr;
    e_r0 = ok && v0 && (!v1 || m_last1);
    e_r1 = ok && v1 && (!v0 || !m_last1);
    a_r0 = r0;
    a_r1 = r1;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_en = 0; m_done = 0; m_last1 = 1; m_addr = '0; m_data = '0; m_caddr = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (m_caddr == NUM_REGS - 1) begin
          m_busy = 0; m_done = 1; m_en = 0;
        end else begin
          m_caddr = m_caddr + 1;
          m_en = 1; m_addr = ADDR_W'(m_caddr); m_data = '0;
        end
      end else if (clr) begin
        m_busy = 1; m_caddr = 0; m_en = 1; m_addr = '0; m_data = '0;
      end else if (e_r0 || e_r1) begin
        m_last1 = e_r1;
        if (ZERO_LOCK != 0 && (e_r1 ? a1 : a0) == '0) m_en = 0;
        else begin
          m_en = 1;
          m_addr = e_r1 ? a1 : a0;
          m_data = e_r1 ? d1 : d0;
        end
      end else m_en = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1; v0 = 1; v1 = 1; a0 = 3; a1 = 4; d0 = $urandom; d1 = $urandom;
    repeat (3) advance();
    rst_n = 0;
    repeat (2) advance();
    total++;
    if ({rf_en, rf_addr, rf_data, busy, done} !== '0) begin
      bad++; $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b done=%b want all 0",
                      rf_en, rf_addr, rf_data, busy, done);
    end
    rst_n = 1;
    advance();
    total++;
    if ({a_r0, a_r1} !== 2'b10) begin
      bad++; $display("FAIL reset_first_grant: got r0=%b r1=%b want r0=1 r1=0", a_r0, a_r1);
    end
    advance();
    total++;
    if ({a_r0, a_r1} !== 2'b01) begin
      bad++; $display("FAIL reset_second_grant: got r0=%b r1=%b want r0=0 r1=1", a_r0, a_r1);
    end
  endtask

  task automatic test_single_write();
    v1 = 0; v0 = 1; a0 = 5; d0 = 32'hDEADBEEF;
    advance();
    total++;
    if ({a_r0, rf_en, rf_addr, rf_data} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL single_write: got r0=%b en=%b addr=%0d data=%h want 1 1 5 deadbeef",
                      a_r0, rf_en, rf_addr, rf_data);
    end
    v0 = 0;
    advance();
    total++;
    if ({rf_en, rf_addr, rf_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL idle_hold: got en=%b addr=%0d data=%h want 0 5 deadbeef",
                      rf_en, rf_addr, rf_data);
    end
  endtask

  task automatic test_alternate();
    int want;
    v1 = 1; a1 = 9; d1 = 32'h11;
    advance();                        // req1 alone, so req0 wins the next contention
    v0 = 1; want = 0;
    for (int i = 0; i < 6; i++) begin
      a0 = ADDR_W'(i + 1); d0 = $urandom; a1 = ADDR_W'(i + 10); d1 = $urandom;
      advance();
      total++;
      if ({a_r0, a_r1} !== ((want == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL alternate[%0d]: got r0=%b r1=%b want grant to req%0d", i, a_r0, a_r1, want);
      end
      total++;
      if ({rf_en, rf_addr, rf_data} !== {1'b1, (want == 0) ? a0 : a1, (want == 0) ? d0 : d1}) begin
        bad++; $display("FAIL alternate_data[%0d]: got en=%b addr=%0d data=%h", i, rf_en, rf_addr, rf_data);
      end
      want = 1 - want;
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_zero_lock();
    v1 = 1; a1 = 0; d1 = 32'h1;
    advance();
    total++;
    if ({a_r1, rf_en} !== 2'b10) begin
      bad++; $display("FAIL zero_lock: got r1=%b en=%b want r1=1 en=0", a_r1, rf_en);
    end
    a1 = 1;
    advance();
    total++;
    if ({a_r1, rf_en, rf_addr, rf_data} !== {1'b1, 1'b1, 5'd1, 32'h1}) begin
      bad++; $display("FAIL zero_lock_next: got r1=%b en=%b addr=%0d data=%h want 1 1 1 00000001",
                      a_r1, rf_en, rf_addr, rf_data);
    end
    v1 = 0;
  endtask

  task automatic test_clear();
    int writes = 0, dones = 0;
    logic done_now;
    v0 = 1; a0 = 7; d0 = $urandom; clr = 1;
    advance();
    total++;
    if (a_r0 !== 1'b0) begin
      bad++; $display("FAIL clear_priority: got r0=%b want 0", a_r0);
    end
    clr = 0;
    for (int c = 0; c < 40 && v0; c++) begin
      done_now = done;
      if (rf_en && busy) begin
        total++;
        if ({rf_addr, rf_data} !== {ADDR_W'(writes), 32'h0}) begin
          bad++; $display("FAIL clear_write[%0d]: got addr=%0d data=%h want addr=%0d data=0",
                          writes, rf_addr, rf_data, writes);
        end
        writes++;
      end
      if (done) dones++;
      advance();
      if (done_now) begin
        total++;
        if (a_r0 !== 1'b1) begin
          bad++; $display("FAIL ready_on_done: got r0=%b want 1", a_r0);
        end
      end
      if (a_r0) v0 = 0;
    end
    total++;
    if (writes != NUM_REGS || dones != 1 || v0) begin
      bad++; $display("FAIL clear_count: got writes=%0d dones=%0d pending=%b want %0d 1 0",
                      writes, dones, v0, NUM_REGS);
    end
    v0 = 0;
  endtask

  task automatic test_clear_abort();
    int writes = 0, dones = 0;
    logic found = 0;
    clr = 1;
    advance();
    clr = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (busy && rf_en && rf_addr == 10) found = 1;
      else advance();
    end
    rst_n = 0;
    advance();
    rst_n = 1;
    total++;
    if (!found || {busy, done, rf_en} !== 3'b000) begin
      bad++; $display("FAIL clear_abort: got found=%b busy=%b done=%b en=%b want 1 0 0 0",
                      found, busy, done, rf_en);
    end
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      advance();
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL abort_no_done: got dones=%0d want 0", dones);
    end
    dones = 0;
    clr = 1;
    advance();
    clr = 0;
    for (int c = 0; c < 45; c++) begin
      if (rf_en && busy) writes++;
      if (done) dones++;
      clr = (c == 5);
      advance();
    end
    clr = 0;
    total++;
    if (writes != NUM_REGS || dones != 1) begin
      bad++; $display("FAIL clear_restart_ignored: got writes=%0d dones=%0d want %0d 1",
                      writes, dones, NUM_REGS);
    end
  endtask

  task automatic test_random();
    logic [41:0] obs, exp;
    for (int c = 0; c < 1500; c++) begin
      if (!v0 && $urandom_range(0, 9) < 6) begin
        v0 = 1; a0 = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 9) < 6) begin
        v1 = 1; a1 = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom); d1 = $urandom;
      end
      clr   = ($urandom_range(0, 99) < 3);
      rst_n = ($urandom_range(0, 199) != 0);
      advance();
      obs = {a_r0, a_r1, rf_en, busy, done, rf_addr, rf_data};
      exp = {e_r0, e_r1, m_en, m_busy, m_done, m_addr, m_data};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL random[%0d]: got r0r1=%b%b en=%b busy=%b done=%b addr=%0d data=%h want %b%b %b %b %b %0d %h",
                        c, a_r0, a_r1, rf_en, busy, done, rf_addr, rf_data,
                        e_r0, e_r1, m_en, m_busy, m_done, m_addr, m_data);
      end
      if (a_r0) v0 = 0;
      if (a_r1) v1 = 0;
    end
    rst_n = 1; clr = 0; v0 = 0; v1 = 0;
  endtask

  initial begin
    rst_n = 0; v0 = 0; v1 = 0; clr = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m_busy = 0; m_en = 0; m_done = 0; m_last1 = 1; m_addr = '0; m_data = '0; m_caddr = 0;
    e_r0 = 0; e_r1 = 0; a_r0 = 0; a_r1 = 0;
    #1;
    advance();
    test_reset();
    test_single_write();
    test_alternate();
    test_zero_lock();
    test_clear();
    test_clear_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
